calc1: RTL and testbench
========================

# calc1

Four-port, 32-bit integer calculator for the calc1 arithmetic-unit subsystem. It sits between four independent requesters and a single shared ALU. Each port issues a command with operand 1, then operand 2 on the next cycle, and receives exactly one one-cycle response carrying a status code and a result. A fixed-priority arbiter serialises the ports onto the ALU.

## Interface
- No parameters. Data width is fixed at 32 bits and there are 4 ports.
- c_clk  in  1  Single clock; all logic is rising-edge.
- reset  in  1  Asynchronous, active-low. 0 clears all state.
- reqN_cmd_in  in  [0:3]  Command for port N (N = 1..4). Encodings:
  - 0: no-op
  - 1: add
  - 2: sub
  - 5: shift left
  - 6: shift right
  - all other codes: invalid
- reqN_data_in  in  [0:31]  Operand 1 in the command cycle; operand 2 in the following cycle.
- out_respN  out  [0:1]  Response for port N:
  - 00: none
  - 01: success
  - 10: overflow, underflow or invalid command
  - 11: reserved, never driven
- out_dataN  out  [0:31]  Result. It is 0 whenever out_respN != 01.
- Bit 0 is the MSB on all vectors.

## Operation
- Each port runs its own state machine with states IDLE → OP2 → PEND → IDLE.
  - IDLE: at a rising edge with cmd != 0, capture cmd and data as operand 1, then go to OP2.
  - OP2: at the next rising edge, capture data as operand 2 unconditionally. The cmd value is ignored. Go to PEND.
  - PEND: wait for an ALU grant. On grant, register the result and go to IDLE.
- A port accepts no new command until its response has been driven. Commands presented outside IDLE are dropped silently.
- Arbiter: one grant per cycle among PEND ports, fixed priority 1 > 2 > 3 > 4.
- ALU rules (unsigned):
  - add: 33-bit sum. Carry-out gives resp 10 and data 0.
  - sub: op1 < op2 gives resp 10 and data 0. Equal operands give 01 with data 0.
  - shift left: logical, amount = op2[27:31] (low 5 bits). Upper op2 bits are ignored. Always 01.
  - shift right: logical, same amount rule. Always 01.
  - invalid: still consumes the operand-2 cycle and arbitration, then returns 10 with data 0.
- Reset (async assert):
  - All out_resp* = 00, all out_data* = 0.
  - All ports go to IDLE.
  - In-flight commands are discarded and never answered.
  - Operation resumes at the first rising edge after deassertion.

## Timing
- Command and operand 1 are sampled at edge E. Operand 2 is sampled at edge E+1.
- Uncontended case: grant in the cycle after E+1. The response register loads at edge E+2. out_respN/out_dataN are valid from E+2 to E+3, exactly one cycle, then return to 00/0.
- Contention: each higher-priority PEND port granted first adds one cycle.
  - Worst case for port 4 with all four ports simultaneous: response valid E+5..E+6.
- Back-to-back: a port may present its next command in the cycle its response is valid. That command is sampled at E+2 at the earliest? No — sampled at the first edge at which the port is IDLE, i.e. E+3 uncontended.
- Responses for different ports may be valid in the same cycle only if they were granted in the same cycle. Since the ALU grants once per cycle, at most one new response appears per cycle.

## Structure
- Package calc1_pkg holds:
  - cmd_t enum: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - resp_t constants: NONE, OK, ERR, RSVD.
  - port_state_t: IDLE, OP2, PEND.
  - Constants NUM_PORTS=4 and DATA_W=32.
- Sub-module calc1_alu: purely combinational; takes cmd, op1 and op2; produces resp and data.
- The top level contains the four port FSMs, the arbiter and the output registers.

## Test plan
- Reset: hold reset=0 for 8 cycles → all out_resp = 00 and out_data = 0. Release, then idle for 5 cycles → still 00.
- Port 1 sub 10 − 3 → out_resp1 = 01 and out_data1 = 7, valid E+2..E+3 only. Sub 3 − 10 → 10 with data 0. Sweep op1 and op2 over 0..10 → 01 and op1 − op2 wherever op1 ≥ op2, 10 otherwise.
- Add 0xFFFFFFFF + 1 → 10 with data 0. Add 0x7FFFFFFF + 1 → 01 with data 0x80000000.
- Shift left 0x1 by op2 = 0x00000021 → 01 with data 0x2 (low 5 bits give an amount of 1). Shift right 0x80000000 by 31 → 01 with data 0x1.
- All four ports issue add 1 + 1 at the same edge E → responses on ports 1, 2, 3, 4 at E+2, E+3, E+4, E+5 respectively, each 01 with data 2.
- Invalid cmd 4 on port 2 → 10 with data 0 at E+2. Assert reset between E and E+2 → no response ever appears.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared types and constants for the calc1 four-port calculator.
package calc1_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 32;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_t;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_NONE = 2'b00;
    localparam resp_t RESP_OK   = 2'b01;
    localparam resp_t RESP_ERR  = 2'b10;
    localparam resp_t RESP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        PEND = 2'd2
    } port_state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational unsigned ALU shared by all calc1 ports.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output resp_t             resp,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W:0] sum_s;
    logic [4:0]      amt_s;

    assign sum_s = {1'b0, op1} + {1'b0, op2};
    assign amt_s = op2[4:0];

    // Result and status; any error forces data to zero.
    always_comb begin
        resp = RESP_ERR;
        data = '0;
        case (cmd)
            ADD: begin
                if (sum_s[DATA_W]) begin
                    resp = RESP_ERR;
                    data = '0;
                end else begin
                    resp = RESP_OK;
                    data = sum_s[DATA_W-1:0];
                end
            end
            SUB: begin
                if (op1 < op2) begin
                    resp = RESP_ERR;
                    data = '0;
                end else begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            SHL: begin
                resp = RESP_OK;
                data = op1 << amt_s;
            end
            SHR: begin
                resp = RESP_OK;
                data = op1 >> amt_s;
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1.sv
// calc1 top: four port FSMs, fixed-priority arbiter (port 1 highest), shared ALU, response registers.
module calc1
    import calc1_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data4
);

    logic [3:0]           cmd_in_s    [NUM_PORTS];
    logic [DATA_W-1:0]    data_in_s   [NUM_PORTS];
    port_state_t          state_r     [NUM_PORTS];
    port_state_t          state_nxt_s [NUM_PORTS];
    logic [3:0]           cmd_r       [NUM_PORTS];
    logic [DATA_W-1:0]    op1_r       [NUM_PORTS];
    logic [DATA_W-1:0]    op2_r       [NUM_PORTS];
    resp_t                resp_r      [NUM_PORTS];
    logic [DATA_W-1:0]    data_r      [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_s;
    logic [1:0]           sel_s;
    logic                 found_s;
    resp_t                alu_resp_s;
    logic [DATA_W-1:0]    alu_data_s;

    assign cmd_in_s[0]  = req1_cmd_in;
    assign cmd_in_s[1]  = req2_cmd_in;
    assign cmd_in_s[2]  = req3_cmd_in;
    assign cmd_in_s[3]  = req4_cmd_in;
    assign data_in_s[0] = req1_data_in;
    assign data_in_s[1] = req2_data_in;
    assign data_in_s[2] = req3_data_in;
    assign data_in_s[3] = req4_data_in;

    // Per-port next state: IDLE -> OP2 -> PEND -> IDLE on grant.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                IDLE: begin
                    if (cmd_in_s[i] != 4'd0) begin
                        state_nxt_s[i] = OP2;
                    end else begin
                        state_nxt_s[i] = IDLE;
                    end
                end
                OP2:  state_nxt_s[i] = PEND;
                PEND: begin
                    if (grant_s[i]) begin
                        state_nxt_s[i] = IDLE;
                    end else begin
                        state_nxt_s[i] = PEND;
                    end
                end
                default: state_nxt_s[i] = IDLE;
            endcase
        end
    end

    // Fixed-priority arbiter: lowest-numbered pending port wins.
    always_comb begin
        grant_s = '0;
        sel_s   = 2'd0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_s && state_r[i] == PEND) begin
                grant_s[i] = 1'b1;
                sel_s      = 2'(i);
                found_s    = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // State register; reset discards any in-flight command.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_r[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Operand capture: cmd/op1 in IDLE, op2 unconditionally in OP2.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cmd_r[i] <= 4'd0;
                op1_r[i] <= '0;
                op2_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (state_r[i] == IDLE && cmd_in_s[i] != 4'd0) begin
                    cmd_r[i] <= cmd_in_s[i];
                    op1_r[i] <= data_in_s[i];
                end else begin
                    cmd_r[i] <= cmd_r[i];
                    op1_r[i] <= op1_r[i];
                end
                if (state_r[i] == OP2) begin
                    op2_r[i] <= data_in_s[i];
                end else begin
                    op2_r[i] <= op2_r[i];
                end
            end
        end
    end

    calc1_alu u_alu (
        .cmd  (cmd_r[sel_s]),
        .op1  (op1_r[sel_s]),
        .op2  (op2_r[sel_s]),
        .resp (alu_resp_s),
        .data (alu_data_s)
    );

    // Response registers: hold a result for exactly the cycle after its grant.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                resp_r[i] <= RESP_NONE;
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_s[i]) begin
                    resp_r[i] <= alu_resp_s;
                    data_r[i] <= alu_data_s;
                end else begin
                    resp_r[i] <= RESP_NONE;
                    data_r[i] <= '0;
                end
            end
        end
    end

    assign out_resp1 = resp_r[0];
    assign out_resp2 = resp_r[1];
    assign out_resp3 = resp_r[2];
    assign out_resp4 = resp_r[3];
    assign out_data1 = data_r[0];
    assign out_data2 = data_r[1];
    assign out_data3 = data_r[2];
    assign out_data4 = data_r[3];

endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: directed table, corner sequences, random traffic vs. a reference model.
module tb_calc1;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [0:3]  cmd_a  [4];
    logic [0:31] data_a [4];
    logic [0:1]  resp_a [4];
    logic [0:31] rdat_a [4];

    int passed = 0;
    int total  = 0;

    always #5 c_clk = ~c_clk;

    calc1 dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_a[0]),
        .req1_data_in (data_a[0]),
        .req2_cmd_in  (cmd_a[1]),
        .req2_data_in (data_a[1]),
        .req3_cmd_in  (cmd_a[2]),
        .req3_data_in (data_a[2]),
        .req4_cmd_in  (cmd_a[3]),
        .req4_data_in (data_a[3]),
        .out_resp1    (resp_a[0]),
        .out_data1    (rdat_a[0]),
        .out_resp2    (resp_a[1]),
        .out_data2    (rdat_a[1]),
        .out_resp3    (resp_a[2]),
        .out_data3    (rdat_a[2]),
        .out_resp4    (resp_a[3]),
        .out_data4    (rdat_a[3])
    );

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [31:0] d;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic rules, result packed as {resp, data}.
    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'b10, 32'd0};
                return {2'b01, s[31:0]};
            end
            4'd2: begin
                if (a < b) return {2'b10, 32'd0};
                return {2'b01, a - b};
            end
            4'd5:    return {2'b01, a << (b % 32)};
            4'd6:    return {2'b01, a >> (b % 32)};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic check_all_idle(input string nm);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s resp%0d", nm, p + 1), 32'(resp_a[p]), 32'd0);
            check($sformatf("%s data%0d", nm, p + 1), rdat_a[p], 32'd0);
        end
    endtask

    // One uncontended transaction; entered and left at a falling edge.
    task automatic run_tx(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed, input string nm);
        cmd_a[p] = c; data_a[p] = a;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[p] = 4'd0; data_a[p] = b;
        @(posedge c_clk);
        @(negedge c_clk); data_a[p] = '0;
        check({nm, " early"}, 32'(resp_a[p]), 32'd0);
        @(posedge c_clk); #1;
        check({nm, " resp"}, 32'(resp_a[p]), 32'(er));
        check({nm, " data"}, rdat_a[p], ed);
        @(posedge c_clk); #1;
        check({nm, " resp after"}, 32'(resp_a[p]), 32'd0);
        check({nm, " data after"}, rdat_a[p], 32'd0);
        @(negedge c_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [33:0] m;
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        int          rp, sel;

        vecs[0] = '{0, 4'd2, 32'd10,         32'd3,         2'b01, 32'd7};
        vecs[1] = '{0, 4'd2, 32'd3,          32'd10,        2'b10, 32'd0};
        vecs[2] = '{0, 4'd1, 32'hFFFF_FFFF,  32'd1,         2'b10, 32'd0};
        vecs[3] = '{0, 4'd1, 32'h7FFF_FFFF,  32'd1,         2'b01, 32'h8000_0000};
        vecs[4] = '{2, 4'd5, 32'd1,          32'h0000_0021, 2'b01, 32'd2};
        vecs[5] = '{3, 4'd6, 32'h8000_0000,  32'd31,        2'b01, 32'd1};
        vecs[6] = '{1, 4'd4, 32'd12,         32'd34,        2'b10, 32'd0};
        vecs[7] = '{0, 4'd2, 32'd5,          32'd5,         2'b01, 32'd0};
        vecs[8] = '{3, 4'd15, 32'd5,         32'd5,         2'b10, 32'd0};
        vecs[9] = '{2, 4'd1, 32'd3,          32'd4,         2'b01, 32'd7};

        for (int p = 0; p < 4; p++) begin
            cmd_a[p] = 4'd0; data_a[p] = '0;
        end

        // Reset held for 8 cycles, then 5 idle cycles.
        repeat (8) @(posedge c_clk);
        @(negedge c_clk);
        check_all_idle("reset");
        reset = 1'b1;
        repeat (5) @(negedge c_clk);
        check_all_idle("post-reset idle");

        for (int i = 0; i < 10; i++) begin
            run_tx(vecs[i].port, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].d,
                   $sformatf("vec%0d", i));
        end

        // Subtraction sweep over 0..10 x 0..10.
        for (int a = 0; a <= 10; a++) begin
            for (int b = 0; b <= 10; b++) begin
                run_tx((a + b) % 4, 4'd2, 32'(a), 32'(b),
                       (a >= b) ? 2'b01 : 2'b10, (a >= b) ? 32'(a - b) : 32'd0,
                       $sformatf("sweep %0d-%0d", a, b));
            end
        end

        // All four ports issue add 1+1 at the same edge.
        for (int p = 0; p < 4; p++) begin cmd_a[p] = 4'd1; data_a[p] = 32'd1; end
        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin cmd_a[p] = 4'd0; data_a[p] = 32'd1; end
        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) data_a[p] = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge c_clk); #1;
            for (int p = 0; p < 4; p++) begin
                check($sformatf("contend E+%0d resp%0d", k + 2, p + 1), 32'(resp_a[p]), (k == p) ? 32'd1 : 32'd0);
                check($sformatf("contend E+%0d data%0d", k + 2, p + 1), rdat_a[p], (k == p) ? 32'd2 : 32'd0);
            end
        end
        @(negedge c_clk);

        // Back-to-back: next command presented while the response is valid.
        cmd_a[0] = 4'd1; data_a[0] = 32'd2;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[0] = 4'd0; data_a[0] = 32'd3;
        @(posedge c_clk);
        @(negedge c_clk); data_a[0] = '0;
        @(posedge c_clk); #1;
        check("b2b first resp", 32'(resp_a[0]), 32'd1);
        check("b2b first data", rdat_a[0], 32'd5);
        cmd_a[0] = 4'd2; data_a[0] = 32'd9;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[0] = 4'd0; data_a[0] = 32'd4;
        @(posedge c_clk);
        @(negedge c_clk); data_a[0] = '0;
        check("b2b second early", 32'(resp_a[0]), 32'd0);
        @(posedge c_clk); #1;
        check("b2b second resp", 32'(resp_a[0]), 32'd1);
        check("b2b second data", rdat_a[0], 32'd5);
        @(negedge c_clk);

        // Commands while OP2/PEND are ignored or dropped.
        cmd_a[1] = 4'd1; data_a[1] = 32'd4;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[1] = 4'd2; data_a[1] = 32'd4;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[1] = 4'd5; data_a[1] = 32'd1;
        @(posedge c_clk); #1;
        check("drop resp", 32'(resp_a[1]), 32'd1);
        check("drop data", rdat_a[1], 32'd8);
        @(negedge c_clk); cmd_a[1] = 4'd0; data_a[1] = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge c_clk);
            check($sformatf("drop quiet %0d", k), 32'(resp_a[1]), 32'd0);
        end

        // Invalid command on port 2 cut short by reset: never answered.
        cmd_a[1] = 4'd4; data_a[1] = 32'd7;
        @(posedge c_clk);
        @(negedge c_clk); cmd_a[1] = 4'd0; data_a[1] = 32'd8;
        @(posedge c_clk); #2;
        reset = 1'b0;
        @(negedge c_clk); data_a[1] = '0;
        check_all_idle("mid-reset");
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge c_clk);
            check($sformatf("discard quiet %0d", k), 32'(resp_a[1]), 32'd0);
        end
        run_tx(1, 4'd1, 32'd20, 32'd22, 2'b01, 32'd42, "resume");

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            rp  = $urandom_range(0, 3);
            sel = $urandom_range(0, 4);
            case (sel)
                0: rc = 4'd1;
                1: rc = 4'd2;
                2: rc = 4'd5;
                3: rc = 4'd6;
                default: rc = 4'($urandom_range(7, 15));
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            m  = model(rc, ra, rb);
            run_tx(rp, rc, ra, rb, m[33:32], m[31:0], $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
